if_stage: RTL

- Instruction-fetch stage of the LEGLite-Stage3 16-bit datapath.
- Sits directly upstream of the instruction memory IM:
  - drives IM's byte address `iaddr`;
  - captures the returned 16-bit `idata` into the IF/ID pipeline register.
- Handles sequential PC advance (+2 bytes), branch redirect from the CBZ resolution logic, pipeline stall and flush.

---
 rtl/if_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the LEGLite-Stage3 16-bit datapath.
//
// Holds the program counter and the IF/ID pipeline register. The PC drives the
// instruction memory directly. The returned word is captured into IF/ID on every
// edge that is neither stalled nor redirected.
//
// Ports
//   clock          in   1   system clock, rising-edge
//   reset_n        in   1   asynchronous active-low reset
//   iaddr          out  16  byte address to IM (= current PC, bit 0 always 0)
//   idata          in   16  instruction word from IM (combinational)
//   stall          in   1   hold PC and IF/ID this cycle
//   branch_taken   in   1   redirect to branch_target and flush IF/ID
//   branch_target  in   16  byte address of the taken branch
//   ifid_instr     out  16  registered instruction to decode
//   ifid_pc2       out  16  registered PC+2 of that instruction
//   ifid_valid     out  1   IF/ID holds a real instruction
//   fetch_count    out  16  (IF_PERF_COUNT_EN only) saturating count of fetches
//   bubble_count   out  16  (IF_PERF_COUNT_EN only) saturating count of redirects
//
// Build option
//   IF_PERF_COUNT_EN : when defined, adds the fetch_count/bubble_count outputs.
//
// Flow control: this stage has no valid/ready handshake. stall is a hold
// request from downstream. While it is high, PC and IF/ID keep their values.
// branch_taken overrides stall, so a redirect and flush always happen on the
// edge where it is seen. The stalled instruction is dropped.
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [15:0] iaddr,
  input  logic [15:0] idata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc2,
  output logic        ifid_valid
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] bubble_count
`endif
);

  logic [15:0] r_pc;
  logic [15:0] r_ifid_instr;
  logic [15:0] r_ifid_pc2;
  logic        r_ifid_valid;

  logic [15:0] w_pc_plus2;
  logic [15:0] w_target_even;
  logic        w_fetch;

  // The sum wraps modulo 2^16. FFFE + 2 returns to 0000 with no carry out.
  assign w_pc_plus2    = r_pc + 16'd2;
  // An odd target is forced even, so bit 0 of the PC can never be set.
  assign w_target_even = {branch_target[15:1], 1'b0};
  assign w_fetch       = !branch_taken && !stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc2   <= 16'h0000;
      r_ifid_valid <= 1'b0;
    end else if (branch_taken) begin
      r_pc         <= w_target_even;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc2   <= 16'h0000;
      r_ifid_valid <= 1'b0;
    end else if (!stall) begin
      r_pc         <= w_pc_plus2;
      r_ifid_instr <= idata;
      r_ifid_pc2   <= w_pc_plus2;
      r_ifid_valid <= 1'b1;
    end
  end

  assign iaddr      = r_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc2   = r_ifid_pc2;
  assign ifid_valid = r_ifid_valid;

`ifdef IF_PERF_COUNT_EN
  logic [15:0] r_fetch_count;
  logic [15:0] r_bubble_count;

  // Both counters saturate at FFFF. Stalled cycles increment neither.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_count  <= 16'h0000;
      r_bubble_count <= 16'h0000;
    end else begin
      if (w_fetch && (r_fetch_count != 16'hFFFF))
        r_fetch_count <= r_fetch_count + 16'd1;
      if (branch_taken && (r_bubble_count != 16'hFFFF))
        r_bubble_count <= r_bubble_count + 16'd1;
    end
  end

  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;
`else
  // Without the counters, w_fetch is used only here. The self-assignment below
  // gives it a reader, so the tools do not report it as unused.
  logic w_fetch_unused;
  assign w_fetch_unused = w_fetch;
`endif

endmodule
